// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and PS/2 protocol byte constants.
package ps2_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_SEND_CMD, S_WAIT_CMD_TX, S_WAIT_ACK1,
        S_SEND_ARG, S_WAIT_ARG_TX, S_WAIT_ACK2, S_ABORT
    } state_t;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_BREAK       = 8'hF0;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    function automatic logic is_reply(input logic [7:0] b);
        return b == PS2_ACK || b == PS2_RESEND;
    endfunction
endpackage

// File: rtl/ps2_led_cmd_ctrl_if.sv
// ps2_led_cmd_ctrl_if: receiver, transmitter, LED-request and scan-forward signals of the command sequencer.
interface ps2_led_cmd_ctrl_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       led_req_valid;
    logic [2:0] led_req_data;
    logic       led_req_ready;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       busy;
    logic       cmd_err;
    modport master (
        input  rx_done_tick, rx_data, tx_idle, tx_done_tick, led_req_valid, led_req_data,
        output tx_start, tx_data, led_req_ready, scan_valid, scan_data, busy, cmd_err
    );
    modport slave (
        output rx_done_tick, rx_data, tx_idle, tx_done_tick, led_req_valid, led_req_data,
        input  tx_start, tx_data, led_req_ready, scan_valid, scan_data, busy, cmd_err
    );
endinterface

// File: rtl/ps2_reply_timer.sv
// ps2_reply_timer: saturating down-counter; load arms a full reply window, expired flags it ran out.
module ps2_reply_timer #(
    parameter int ACK_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(ACK_TIMEOUT);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_load) r_cnt <= W'(ACK_TIMEOUT - 1);
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_expired = r_cnt == '0;
endmodule

// File: rtl/ps2_led_cmd_ctrl.sv
// ps2_led_cmd_ctrl: sends 0xED + LED argument to the keyboard with ACK/RESEND tracking,
// and forwards every non-reply received byte to the scan-code path.
module ps2_led_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 1_000_000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] CMD_SET_LED = PS2_CMD_SET_LED
) (
    input logic clk,
    input logic reset,
    ps2_led_cmd_ctrl_if.master bus
);
    state_t     r_state, w_next;
    logic [2:0] r_retry, r_led;
    logic [7:0] r_tx_data, r_scan_data;
    logic       r_scan_valid;
    logic       w_ack, w_rsd, w_can_retry, w_expired;
    logic       w_send, w_wait_tx, w_in_ack, w_load, w_clear;

    assign w_ack       = bus.rx_done_tick && bus.rx_data == PS2_ACK;
    assign w_rsd       = bus.rx_done_tick && bus.rx_data == PS2_RESEND;
    assign w_can_retry = r_retry < 3'(MAX_RETRY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // A received reply takes priority over a timeout landing on the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = bus.led_req_valid ? S_SEND_CMD : S_IDLE;
            S_SEND_CMD:    w_next = bus.tx_idle ? S_WAIT_CMD_TX : S_SEND_CMD;
            S_WAIT_CMD_TX: w_next = bus.tx_done_tick ? S_WAIT_ACK1 : S_WAIT_CMD_TX;
            S_WAIT_ACK1:   w_next = w_ack ? S_SEND_ARG : w_rsd ? (w_can_retry ? S_SEND_CMD : S_ABORT)
                                  : w_expired ? S_ABORT : S_WAIT_ACK1;
            S_SEND_ARG:    w_next = bus.tx_idle ? S_WAIT_ARG_TX : S_SEND_ARG;
            S_WAIT_ARG_TX: w_next = bus.tx_done_tick ? S_WAIT_ACK2 : S_WAIT_ARG_TX;
            S_WAIT_ACK2:   w_next = w_ack ? S_IDLE : w_rsd ? (w_can_retry ? S_SEND_ARG : S_ABORT)
                                  : w_expired ? S_ABORT : S_WAIT_ACK2;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_send            = (r_state == S_SEND_CMD || r_state == S_SEND_ARG) && bus.tx_idle;
        w_wait_tx         = r_state == S_WAIT_CMD_TX || r_state == S_WAIT_ARG_TX;
        w_in_ack          = r_state == S_WAIT_ACK1 || r_state == S_WAIT_ACK2;
        w_load            = w_wait_tx && bus.tx_done_tick;
        w_clear           = r_state == S_IDLE;
        bus.tx_start      = w_send;
        bus.led_req_ready = r_state == S_IDLE;
        bus.busy          = r_state != S_IDLE;
        bus.cmd_err       = r_state == S_ABORT;
    end

    // tx_data is loaded on entry to a SEND state so it is already valid when tx_start fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry      <= '0;
            r_led        <= '0;
            r_tx_data    <= '0;
            r_scan_valid <= 1'b0;
            r_scan_data  <= '0;
        end else begin
            if (r_state == S_IDLE || (w_ack && r_state == S_WAIT_ACK1)) r_retry <= '0;
            else if (w_rsd && w_in_ack && w_can_retry) r_retry <= r_retry + 3'd1;
            if (r_state == S_IDLE && bus.led_req_valid) r_led <= bus.led_req_data;
            if (w_next == S_SEND_CMD) r_tx_data <= CMD_SET_LED;
            else if (w_next == S_SEND_ARG) r_tx_data <= {5'b0, r_led};
            r_scan_valid <= bus.rx_done_tick && !is_reply(bus.rx_data);
            if (bus.rx_done_tick && !is_reply(bus.rx_data)) r_scan_data <= bus.rx_data;
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_data  = r_scan_data;

    ps2_reply_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_load    (w_load),
        .i_en      (w_in_ack),
        .o_expired (w_expired)
    );
endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
// tb_ps2_led_cmd_ctrl: transmitter + scripted keyboard around the sequencer; a transaction-level
// model predicts transmitted bytes, error pulses and forwarded scan bytes.
module tb_ps2_led_cmd_ctrl;
    import ps2_pkg::*;
    localparam int TO = 100;
    localparam int MR = 3;

    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;

    ps2_led_cmd_ctrl_if bus();
    ps2_led_cmd_ctrl #(.ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (.clk(clk), .reset(reset), .bus(bus));

    int passed = 0, total = 0;
    int cyc = 0, last_done = -1000, err_cnt = 0, rel = 0, k = 0, kb_r = 0;
    logic [7:0] exp_tx[$], tx_log[$], fwd_byte = 0, kb_b = 0;
    int tx_cyc[$], replies[$];
    bit exp_timeout = 0, fwd_pend = 0, tx_free = 1, stall = 0, reset_hit = 0;
    int noise_mode = 0;

    assign bus.tx_idle = tx_free && !stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] rnd_scan();
        logic [7:0] v = 8'($urandom_range(0, 255));
        return is_reply(v) ? 8'h1C : v;
    endfunction

    // Caller must be positioned at a posedge.
    task automatic send_rx(input logic [7:0] b);
        #1 bus.rx_data = b;
        bus.rx_done_tick = 1;
        @(posedge clk);
        #1 bus.rx_done_tick = 0;
    endtask

    // Per-cycle compare: forwarding, ready/busy relation, transmitted bytes, error pulses.
    always @(negedge clk) begin
        cyc++;
        chk("ready_vs_busy", bus.led_req_ready, !bus.busy);
        if (fwd_pend) begin
            chk("scan_valid", bus.scan_valid, 1);
            chk("scan_data", bus.scan_data, fwd_byte);
        end else chk("no_scan", bus.scan_valid, 0);
        fwd_pend = !reset && bus.rx_done_tick && bus.rx_data != 8'hFA && bus.rx_data != 8'hFE;
        fwd_byte = bus.rx_data;
        if (bus.tx_done_tick) last_done = cyc;
        if (bus.tx_start) begin
            chk("tx_start_idle", bus.tx_idle, 1);
            chk("tx_start_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) chk("tx_byte", bus.tx_data, exp_tx.pop_front());
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
        end
        if (bus.cmd_err) begin
            err_cnt++;
            if (exp_timeout) chk("timeout_latency", cyc - last_done, TO + 1);
        end
    end

    // Transmitter and keyboard: clocks a byte out, then answers from the reply script (-1 = silence).
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start && !reset) begin
                kb_b = bus.tx_data;
                @(posedge clk);
                #1 tx_free = 0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 bus.tx_done_tick = 1;
                @(posedge clk);
                #1 bus.tx_done_tick = 0;
                tx_free = 1;
                if (!reset_hit) chk("tx_data_stable", bus.tx_data, kb_b);
                kb_r = replies.size() != 0 ? replies.pop_front() : -1;
                if (kb_r >= 0) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    if (noise_mode == 1) send_rx(8'h1C);
                    else if (noise_mode == 2 && $urandom_range(0, 2) == 0) send_rx(rnd_scan());
                    send_rx(8'(kb_r));
                end
            end
        end
    end

    // cfe/afe: RESEND replies to the command/argument; to: 1/2 = silence after command/argument.
    task automatic run_txn(input logic [2:0] leds, input int cfe, input int afe, input int to);
        int n, w;
        bit ab;
        exp_tx.delete(); replies.delete(); tx_log.delete(); tx_cyc.delete();
        err_cnt = 0;
        n = cfe > MR ? MR + 1 : cfe + 1;
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(8'hED);
            replies.push_back(i < cfe ? 254 : (to == 1 ? -1 : 250));
        end
        ab = cfe > MR || to == 1;
        exp_timeout = to == 1 && cfe <= MR;
        if (!ab) begin
            n = afe > MR ? MR + 1 : afe + 1;
            for (int i = 0; i < n; i++) begin
                exp_tx.push_back({5'b0, leds});
                replies.push_back(i < afe ? 254 : (to == 2 ? -1 : 250));
            end
            ab = afe > MR || to == 2;
            exp_timeout = to == 2 && afe <= MR;
        end
        @(posedge clk);
        #1 bus.led_req_valid = 1;
        bus.led_req_data = leds;
        @(posedge clk);
        #1 bus.led_req_valid = 0;
        w = 0;
        do begin @(negedge clk); w++; end while (!(bus.led_req_ready && exp_tx.size() == 0) && w < 3000);
        chk("txn_done_in_time", w < 3000, 1);
        @(negedge clk);
        chk("tx_bytes_left", exp_tx.size(), 0);
        chk("replies_left", replies.size(), 0);
        chk("cmd_err_count", err_cnt, ab);
        exp_timeout = 0;
    endtask

    initial begin
        bus.rx_done_tick = 0; bus.rx_data = 0; bus.tx_done_tick = 0;
        bus.led_req_valid = 0; bus.led_req_data = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.led_req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_scan_valid", bus.scan_valid, 0);
        chk("rst_cmd_err", bus.cmd_err, 0);
        reset = 0;

        run_txn(3'b100, 0, 0, 0);
        chk("caps_n", tx_log.size(), 2);
        chk("caps_b0", tx_log[0], 8'hED);
        chk("caps_b1", tx_log[1], 8'h04);

        run_txn(3'b100, 2, 0, 0);
        chk("resend_n", tx_log.size(), 4);
        chk("resend_b2", tx_log[2], 8'hED);
        chk("resend_b3", tx_log[3], 8'h04);

        run_txn(3'b100, 4, 0, 0);
        chk("abort_n", tx_log.size(), 4);
        chk("abort_err", err_cnt, 1);

        run_txn(3'b010, 0, 0, 1);
        chk("timeout_n", tx_log.size(), 1);
        run_txn(3'b001, 0, 1, 2);
        chk("timeout_arg_n", tx_log.size(), 3);

        noise_mode = 1;
        run_txn(3'b111, 0, 0, 0);
        noise_mode = 0;
        chk("pass_n", tx_log.size(), 2);

        @(posedge clk);
        send_rx(8'hFA);
        send_rx(8'hFE);
        send_rx(8'h5A);
        repeat (3) @(posedge clk);

        stall = 1;
        fork
            run_txn(3'b100, 0, 0, 0);
            begin
                repeat (50) @(posedge clk);
                #1 stall = 0;
                rel = cyc;
            end
        join
        chk("bp_n", tx_log.size(), 2);
        chk("bp_first_start", tx_cyc[0], rel + 1);

        exp_tx.delete(); tx_log.delete(); replies.delete();
        replies.push_back(250);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h05);
        @(posedge clk);
        #1 bus.led_req_valid = 1;
        bus.led_req_data = 3'b101;
        @(posedge clk);
        #1 bus.led_req_valid = 0;
        k = 0;
        while (tx_log.size() < 2 && k < 500) begin @(negedge clk); k++; end
        chk("reach_arg", tx_log.size(), 2);
        @(negedge clk);
        chk("in_wait_arg", bus.busy, 1);
        #2 reset_hit = 1;
        reset = 1;
        #1;
        chk("arst_ready", bus.led_req_ready, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_tx_start", bus.tx_start, 0);
        chk("arst_tx_data", bus.tx_data, 0);
        chk("arst_scan_valid", bus.scan_valid, 0);
        chk("arst_cmd_err", bus.cmd_err, 0);
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (200) @(posedge clk);
        chk("no_tx_after_reset", tx_log.size(), 2);
        reset_hit = 0;

        noise_mode = 2;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 4);
            run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 4), k > 2 ? 0 : k);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                send_rx(rnd_scan());
            end
        end
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ps2_led_cmd_ctrl.md
Name: ps2_led_cmd_ctrl

Overview:
- Host-to-keyboard command sequencer for the PS/2 keyboard path.
- Accepts LED update requests (scroll/num/caps) from the CPU-side control logic and issues the 0xED + argument transaction through the PS/2 transmitter.
- Tracks 0xFA (ACK) and 0xFE (RESEND) replies from the PS/2 receiver, retrying or timing out as needed.
- Forwards every other received byte untouched to the scan-code decoder, so protocol replies never reach the keyboard FSM.

Parameters:
- ACK_TIMEOUT, 1_000_000, clk cycles to wait for a keyboard reply after each tx_done_tick (20 ms at 50 MHz).
- MAX_RETRY, 3, resend attempts per byte before abort; range 1..7.
- CMD_SET_LED, 8'hED, set-LED command byte.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe: receiver has a byte.
- rx_data  in  8  received byte, valid with rx_done_tick.
- tx_idle  in  1  transmitter can accept a byte.
- tx_done_tick  in  1  one-cycle strobe: byte fully clocked out.
- tx_start  out  1  one-cycle strobe to start a transmission.
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_done_tick.
- led_req_valid  in  1  LED update request.
- led_req_data  in  3  {caps, num, scroll}.
- led_req_ready  out  1  request accepted when valid && ready.
- scan_valid  out  1  forwarded-byte strobe.
- scan_data  out  8  forwarded byte.
- busy  out  1  transaction in progress.
- cmd_err  out  1  one-cycle pulse on abort (retries exhausted or timeout).

Behaviour:
- Reset values:
  - state = IDLE.
  - tx_start, scan_valid, busy, cmd_err = 0; led_req_ready = 1.
  - tx_data = 0, scan_data = 0.
  - retry count, timeout counter and latched LED bits = 0.
- Reset mid-transaction returns to IDLE immediately. No partial byte is re-issued.
- Forwarding (all states):
  - Any rx byte other than 0xFA/0xFE produces scan_valid = 1 and scan_data = rx_data on the next cycle (1-cycle registered latency).
  - 0xFA/0xFE are always consumed and never forwarded, including in IDLE, where they are dropped silently.
- led_req_ready = 1 only in IDLE. On handshake, latch led_req_data and go to SEND_CMD. Clear retry_cnt.
- SEND_CMD:
  - Wait for tx_idle.
  - Drive tx_data = CMD_SET_LED and pulse tx_start for one cycle.
  - Go to WAIT_CMD_TX.
- WAIT_CMD_TX: on tx_done_tick, clear the timeout counter and go to WAIT_ACK1.
- WAIT_ACK1:
  - rx 0xFA: go to SEND_ARG and clear retry_cnt.
  - rx 0xFE: if retry_cnt < MAX_RETRY, increment it and go back to SEND_CMD; otherwise go to ABORT.
  - Counter reaches ACK_TIMEOUT-1: go to ABORT.
- SEND_ARG: drive tx_data = {5'b0, caps, num, scroll} and pulse tx_start once tx_idle is high. Go to WAIT_ARG_TX.
- WAIT_ARG_TX: on tx_done_tick, clear the counter and go to WAIT_ACK2.
- WAIT_ACK2:
  - 0xFA: go to IDLE (success).
  - 0xFE: retry SEND_ARG under the same retry rule.
  - Timeout: go to ABORT.
- ABORT: pulse cmd_err for one cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- Simultaneous events:
  - rx_done_tick on the same cycle as the timeout terminal count: the rx byte wins.
  - rx_done_tick during WAIT_*_TX is only forwarded or consumed; it never advances the FSM.
- Timeout counter:
  - Sized to $clog2(ACK_TIMEOUT).
  - Counts only in WAIT_ACK1/2.
  - Saturates; does not wrap.
- A new request arriving while busy is held off (ready = 0). No queueing.

Decomposition:
- Package ps2_pkg holds:
  - the state enum;
  - constants PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE, PS2_BREAK = 8'hF0, PS2_CMD_SET_LED = 8'hED.
- One sub-module, ps2_reply_timer: a loadable saturating down-counter with clear, load and expired signals, parameterised by ACK_TIMEOUT.

Test Plan:
- Set caps: led_req_data = 3'b100. Model sends 0xFA after each byte. Expect tx bytes 0xED then 0x04, busy high throughout, led_req_ready back to 1, no cmd_err, no scan_valid for the 0xFA bytes.
- Resend path: model replies 0xFE to 0xED twice, then 0xFA. Expect 0xED transmitted 3 times, then 0x04, success. With MAX_RETRY=3, four 0xFE replies produce exactly one cmd_err pulse and a return to IDLE.
- Timeout: ACK_TIMEOUT = 100, no reply after 0xED. Expect cmd_err exactly 100 cycles after tx_done_tick (±1 documented), then IDLE.
- Passthrough during transaction: rx 0x1C arrives in WAIT_ACK1. Expect scan_valid with scan_data = 0x1C one cycle later and the FSM still in WAIT_ACK1. A stray 0xFA in IDLE produces no scan_valid.
- Reset mid-transaction: assert reset while in WAIT_ARG_TX. Expect all outputs at their reset values asynchronously and tx_start never asserted after release until a new request.
- Back-pressure: hold tx_idle = 0 for 50 cycles in SEND_CMD. Expect tx_start asserted exactly once, on the first cycle tx_idle = 1.
